regfile_writeback_arbiter: RTL and testbench

//   Writer side of the register-file write port (write_enable/dest_addr/write_data).

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 58 +++++
 rtl/regfile_writeback_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path: entry layout and source ids.
package wb_pkg;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 64;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for writeback entries; exposes storage and read pointer so the
// top level can search queued entries in age order.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int W     = WB_ADDR_W + WB_DATA_W,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic [W-1:0]            din_i,
  input  logic                    pop_i,
  output logic [W-1:0]            head_o,
  output logic [CW-1:0]           count_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [DEPTH-1:0][W-1:0] mem_o,
  output logic [PW-1:0]           rd_ptr_o
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;
  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_ptr_q;
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Round-robin ALU/MEM writeback arbiter feeding a FIFO that drains into registered
// RF write-port outputs. Optional forwarding search enabled by WB_FWD_EN.
module regfile_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int BIT_NUMBER  = 64,
  parameter int ADDR_NUMBER = 5,
  parameter int FIFO_DEPTH  = 4,
  localparam int PW         = $clog2(FIFO_DEPTH),
  localparam int CW         = PW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   src0_valid,
  output logic                   src0_ready,
  input  logic [ADDR_NUMBER-1:0] src0_addr,
  input  logic [BIT_NUMBER-1:0]  src0_data,
  input  logic                   src1_valid,
  output logic                   src1_ready,
  input  logic [ADDR_NUMBER-1:0] src1_addr,
  input  logic [BIT_NUMBER-1:0]  src1_data,
  input  logic                   rf_stall,
  output logic                   rf_write_enable,
  output logic [ADDR_NUMBER-1:0] rf_dest_addr,
  output logic [BIT_NUMBER-1:0]  rf_write_data,
  output logic [CW-1:0]          fifo_count,
  output logic                   wb_idle
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_NUMBER-1:0] fwd_addr_1,
  input  logic [ADDR_NUMBER-1:0] fwd_addr_2,
  output logic                   fwd_hit_1,
  output logic                   fwd_hit_2,
  output logic [BIT_NUMBER-1:0]  fwd_data_1,
  output logic [BIT_NUMBER-1:0]  fwd_data_2
`endif
);
  localparam int EW = ADDR_NUMBER + BIT_NUMBER;

  wb_src_e                         rr_q;
  logic                            grant0, grant1, full, empty, pop;
  logic [EW-1:0]                   push_entry, head;
  logic [FIFO_DEPTH-1:0][EW-1:0]   fifo_mem;
  logic [PW-1:0]                   fifo_rd_ptr;
  logic                            rf_we_q;
  logic [ADDR_NUMBER-1:0]          rf_addr_q;
  logic [BIT_NUMBER-1:0]           rf_data_q;

  // Grant depends only on occupancy, never on this cycle's pop.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!full) begin
      if (src0_valid && (!src1_valid || rr_q == SRC_ALU)) grant0 = 1'b1;
      else if (src1_valid)                                grant1 = 1'b1;
    end
  end

  assign push_entry = grant1 ? {src1_addr, src1_data} : {src0_addr, src0_data};
  assign pop        = !empty && !rf_stall;

  wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (grant0 | grant1),
    .din_i   (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty),
    .mem_o   (fifo_mem),
    .rd_ptr_o(fifo_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q      <= SRC_ALU;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= pop;
      if (pop) {rf_addr_q, rf_data_q} <= head;
      if (grant0)      rr_q <= SRC_MEM;
      else if (grant1) rr_q <= SRC_ALU;
    end
  end

  assign src0_ready      = grant0;
  assign src1_ready      = grant1;
  assign rf_write_enable = rf_we_q;
  assign rf_dest_addr    = rf_addr_q;
  assign rf_write_data   = rf_data_q;
  assign wb_idle         = empty && !rf_we_q;

`ifdef WB_FWD_EN
  logic [1:0][ADDR_NUMBER-1:0] fa;
  logic [1:0]                  fh;
  logic [1:0][BIT_NUMBER-1:0]  fd;
  logic [PW-1:0]               idx;

  assign fa = {fwd_addr_2, fwd_addr_1};

  // The output register is older than any queued entry; scanning the FIFO
  // oldest-first lets the youngest match overwrite earlier ones.
  always_comb begin
    fh  = '0;
    fd  = '0;
    idx = '0;
    for (int k = 0; k < 2; k++) begin
      if (rf_we_q && rf_addr_q == fa[k]) begin
        fh[k] = 1'b1;
        fd[k] = rf_data_q;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        idx = fifo_rd_ptr + PW'(i);
        if (CW'(i) < fifo_count && fifo_mem[idx][EW-1 -: ADDR_NUMBER] == fa[k]) begin
          fh[k] = 1'b1;
          fd[k] = fifo_mem[idx][BIT_NUMBER-1:0];
        end
      end
    end
  end

  assign fwd_hit_1  = fh[0];
  assign fwd_hit_2  = fh[1];
  assign fwd_data_1 = fd[0];
  assign fwd_data_2 = fd[1];
`else
  logic unused_fwd_view;
  assign unused_fwd_view = ^{fifo_mem, fifo_rd_ptr};
`endif
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomized plus directed bench for regfile_writeback_arbiter against a queue model.
module tb_regfile_writeback_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        src0_valid = 1'b0, src1_valid = 1'b0;
  logic        src0_ready, src1_ready;
  logic [4:0]  src0_addr = '0, src1_addr = '0;
  logic [63:0] src0_data = '0, src1_data = '0;
  logic        rf_stall = 1'b0;
  logic        rf_write_enable;
  logic [4:0]  rf_dest_addr;
  logic [63:0] rf_write_data;
  logic [2:0]  fifo_count;
  logic        wb_idle;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_addr_1 = '0, fwd_addr_2 = '0;
  logic        fwd_hit_1, fwd_hit_2;
  logic [63:0] fwd_data_1, fwd_data_2;
`endif

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.BIT_NUMBER(64), .ADDR_NUMBER(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_addr(src0_addr), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_addr(src1_addr), .src1_data(src1_data),
    .rf_stall(rf_stall), .rf_write_enable(rf_write_enable), .rf_dest_addr(rf_dest_addr),
    .rf_write_data(rf_write_data), .fifo_count(fifo_count), .wb_idle(wb_idle)
`ifdef WB_FWD_EN
    , .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2), .fwd_hit_1(fwd_hit_1),
    .fwd_hit_2(fwd_hit_2), .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [68:0] rf_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of accepted writes plus the preferred source.
  wb_entry_t   m_q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_data = '0;
  bit          m_pref_mem = 1'b0;

  always begin
    wb_entry_t ent;
    bit        e0, e1;
    @(negedge clk);
    #2;
    chk("rf_write_enable", {63'd0, rf_write_enable}, {63'd0, m_we});
    chk("rf_dest_addr", {59'd0, rf_dest_addr}, {59'd0, m_addr});
    chk("rf_write_data", rf_write_data, m_data);
    chk("fifo_count", {61'd0, fifo_count}, 64'(m_q.size()));
    chk("wb_idle", {63'd0, wb_idle}, {63'd0, (m_q.size() == 0 && !m_we)});
    if (rf_write_enable === 1'b1) rf_log.push_back({rf_dest_addr, rf_write_data});
    e0 = 1'b0;
    e1 = 1'b0;
    if (m_q.size() < DEPTH) begin
      if (src0_valid && src1_valid) begin
        e0 = !m_pref_mem;
        e1 = m_pref_mem;
      end else begin
        e0 = src0_valid;
        e1 = src1_valid;
      end
    end
    chk("src0_ready", {63'd0, src0_ready}, {63'd0, e0});
    chk("src1_ready", {63'd0, src1_ready}, {63'd0, e1});
    if (reset) begin
      m_q.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0; m_pref_mem = 1'b0;
    end else begin
      if (m_q.size() > 0 && !rf_stall) begin
        ent = m_q.pop_front();
        m_we = 1'b1; m_addr = ent.addr; m_data = ent.data;
      end else m_we = 1'b0;
      if (e0) begin
        ent.addr = src0_addr; ent.data = src0_data; m_q.push_back(ent); m_pref_mem = 1'b1;
      end else if (e1) begin
        ent.addr = src1_addr; ent.data = src1_data; m_q.push_back(ent); m_pref_mem = 1'b0;
      end
    end
  end

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                       input logic st, input logic rs);
    @(negedge clk);
    src0_valid = v0; src0_addr = a0; src0_data = d0;
    src1_valid = v1; src1_addr = a1; src1_data = d1;
    rf_stall = st; reset = rs;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int acc;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
    chk("reset_count", {61'd0, fifo_count}, 64'd0);
    chk("reset_we", {63'd0, rf_write_enable}, 64'd0);
    chk("reset_idle", {63'd0, wb_idle}, 64'd1);

    // Single ALU write: accepted, written one cycle later, then idle.
    drive(1'b1, 5'd3, 64'hAA, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    chk("t1_ready0", {63'd0, src0_ready}, 64'd1);
    idle(1);
    chk("t1_we_latency", {63'd0, rf_write_enable}, 64'd0);
    idle(1);
    chk("t1_we", {63'd0, rf_write_enable}, 64'd1);
    chk("t1_addr", {59'd0, rf_dest_addr}, 64'd3);
    chk("t1_data", rf_write_data, 64'hAA);
    idle(1);
    chk("t1_we_off", {63'd0, rf_write_enable}, 64'd0);
    chk("t1_addr_hold", {59'd0, rf_dest_addr}, 64'd3);
    chk("t1_idle", {63'd0, wb_idle}, 64'd1);

    // Both sources always valid: strict alternation starting from ALU after reset.
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
    idle(1);
    rf_log.delete();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 5'(k), 64'h100 + 64'(k), 1'b1, 5'(16 + k), 64'h200 + 64'(k), 1'b0, 1'b0);
      chk("t2_ready0", {63'd0, src0_ready}, 64'((k % 2) == 0));
      chk("t2_ready1", {63'd0, src1_ready}, 64'((k % 2) == 1));
    end
    idle(3);
    chk("t2_nwrites", 64'(rf_log.size()), 64'd8);
    for (int k = 0; k < rf_log.size() && k < 8; k++)
      chk("t2_order", rf_log[k][63:0], ((k % 2) == 0) ? 64'h100 + 64'(k) : 64'h200 + 64'(k));

    // Stalled queue fills to depth, back-pressures, then drains in order.
    rf_log.delete();
    acc = 0;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 5'd10, 64'h300 + 64'(acc), 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
      chk("t3_fill_ready", {63'd0, src0_ready}, 64'(c < 4));
      if (src0_ready) acc++;
    end
    chk("t3_full_count", {61'd0, fifo_count}, 64'd4);
    drive(1'b1, 5'd10, 64'h300 + 64'(acc), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    chk("t3_no_stall_path", {63'd0, src0_ready}, 64'd0);
    drive(1'b1, 5'd10, 64'h300 + 64'(acc), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    chk("t3_fifth_ready", {63'd0, src0_ready}, 64'd1);
    idle(7);
    chk("t3_nwrites", 64'(rf_log.size()), 64'd5);
    for (int k = 0; k < rf_log.size() && k < 5; k++)
      chk("t3_order", rf_log[k][63:0], 64'h300 + 64'(k));

    // Same address from both sources keeps acceptance order.
    rf_log.delete();
    drive(1'b1, 5'd7, 64'd1, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'd2, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
`ifdef WB_FWD_EN
    fwd_addr_1 = 5'd7;
    fwd_addr_2 = 5'd8;
    #1;
    chk("t4_fwd_hit1", {63'd0, fwd_hit_1}, 64'd1);
    chk("t4_fwd_data1", fwd_data_1, 64'd2);
    chk("t4_fwd_hit2", {63'd0, fwd_hit_2}, 64'd0);
    chk("t4_fwd_data2", fwd_data_2, 64'd0);
`endif
    idle(4);
    chk("t4_nwrites", 64'(rf_log.size()), 64'd2);
    if (rf_log.size() == 2) begin
      chk("t4_first", {59'd0, rf_log[0][68:64], rf_log[0][63:0] == 64'd1}, {59'd0, 5'd7, 1'b1});
      chk("t4_second", {59'd0, rf_log[1][68:64], rf_log[1][63:0] == 64'd2}, {59'd0, 5'd7, 1'b1});
    end

    // Reset with queued entries discards them.
    rf_log.delete();
    for (int c = 0; c < 3; c++)
      drive(1'b1, 5'(20 + c), 64'h500 + 64'(c), 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1);
    chk("t5_count_before", {61'd0, fifo_count}, 64'd3);
    idle(1);
    chk("t5_count", {61'd0, fifo_count}, 64'd0);
    chk("t5_we", {63'd0, rf_write_enable}, 64'd0);
    chk("t5_idle", {63'd0, wb_idle}, 64'd1);
    idle(4);
    chk("t5_no_writes", 64'(rf_log.size()), 64'd0);

    // Random traffic with alternating stall-heavy and stall-light phases.
    for (int n = 0; n < 600; n++) begin
      logic st;
      st = ((n % 100) < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
            st, ($urandom_range(0, 99) == 0));
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
